// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory read/write channel among per-thread LSUs.
// One transaction in flight; the grant is held through the memory handshake and the LSU release.
module lsu_mem_arbiter #(
    parameter int unsigned THREADS_PER_BLOCK = 4,
    parameter int unsigned ADDR_BITS         = 8,
    parameter int unsigned DATA_BITS         = 8
) (
    input  logic                                           clk,
    input  logic                                           reset,

    input  logic [THREADS_PER_BLOCK-1:0]                   req_read_valid,
    input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]    req_read_address,
    output logic [THREADS_PER_BLOCK-1:0]                   req_read_ready,
    output logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]    req_read_data,

    input  logic [THREADS_PER_BLOCK-1:0]                   req_write_valid,
    input  logic [THREADS_PER_BLOCK-1:0][ADDR_BITS-1:0]    req_write_address,
    input  logic [THREADS_PER_BLOCK-1:0][DATA_BITS-1:0]    req_write_data,
    output logic [THREADS_PER_BLOCK-1:0]                   req_write_ready,

    output logic                                           mem_read_valid,
    output logic [ADDR_BITS-1:0]                           mem_read_address,
    input  logic                                           mem_read_ready,
    input  logic [DATA_BITS-1:0]                           mem_read_data,

    output logic                                           mem_write_valid,
    output logic [ADDR_BITS-1:0]                           mem_write_address,
    output logic [DATA_BITS-1:0]                           mem_write_data,
    input  logic                                           mem_write_ready,

    output logic                                           busy
);

    localparam int unsigned T     = THREADS_PER_BLOCK;
    localparam int unsigned PTR_W = (T > 1) ? $clog2(T) : 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } state_t;

    state_t                         r_state,    w_state;
    logic [PTR_W-1:0]               r_g,        w_g;
    logic [PTR_W-1:0]               r_ptr,      w_ptr;
    logic [T-1:0][DATA_BITS-1:0]    r_rd_data,  w_rd_data;
    logic [T-1:0]                   r_rd_rdy,   w_rd_rdy;
    logic [T-1:0]                   r_wr_rdy,   w_wr_rdy;
    logic                           r_mem_rv,   w_mem_rv;
    logic                           r_mem_wv,   w_mem_wv;
    logic [ADDR_BITS-1:0]           r_mem_ra,   w_mem_ra;
    logic [ADDR_BITS-1:0]           r_mem_wa,   w_mem_wa;
    logic [DATA_BITS-1:0]           r_mem_wd,   w_mem_wd;
    logic                           r_busy,     w_busy;

    logic [T-1:0]                   w_pending;
    logic                           w_hit;
    logic [PTR_W-1:0]               w_sel;
    logic                           w_release;

    // Modulo-T increment; T need not be a power of two.
    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= T) begin
            s = s - T;
        end
        return PTR_W'(s);
    endfunction

    assign w_pending = req_read_valid | req_write_valid;

    // First pending thread at or after the round-robin pointer.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int unsigned k = 0; k < T; k++) begin
            if (!w_hit && w_pending[wrap_add(r_ptr, k)]) begin
                w_hit = 1'b1;
                w_sel = wrap_add(r_ptr, k);
            end
        end
    end

    // Granted LSU has dropped the valid matching the completed transaction type.
    assign w_release = (r_rd_rdy[r_g] && !req_read_valid[r_g]) ||
                       (r_wr_rdy[r_g] && !req_write_valid[r_g]);

    // Next-state and next-output logic.
    always_comb begin
        w_state   = r_state;
        w_g       = r_g;
        w_ptr     = r_ptr;
        w_rd_data = r_rd_data;
        w_rd_rdy  = r_rd_rdy;
        w_wr_rdy  = r_wr_rdy;
        w_mem_rv  = r_mem_rv;
        w_mem_wv  = r_mem_wv;
        w_mem_ra  = r_mem_ra;
        w_mem_wa  = r_mem_wa;
        w_mem_wd  = r_mem_wd;

        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    w_g = w_sel;
                    if (req_read_valid[w_sel]) begin
                        w_mem_ra = req_read_address[w_sel];
                        w_mem_rv = 1'b1;
                        w_state  = READ_WAIT;
                    end else begin
                        w_mem_wa = req_write_address[w_sel];
                        w_mem_wd = req_write_data[w_sel];
                        w_mem_wv = 1'b1;
                        w_state  = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    w_rd_data[r_g] = mem_read_data;
                    w_rd_rdy[r_g]  = 1'b1;
                    w_mem_rv       = 1'b0;
                    w_state        = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    w_wr_rdy[r_g] = 1'b1;
                    w_mem_wv      = 1'b0;
                    w_state       = RELAY;
                end
            end
            RELAY: begin
                if (w_release) begin
                    w_rd_rdy = '0;
                    w_wr_rdy = '0;
                    w_ptr    = wrap_add(r_g, 1);
                    w_state  = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_busy = (w_state != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_g       <= '0;
            r_ptr     <= '0;
            r_rd_data <= '0;
            r_rd_rdy  <= '0;
            r_wr_rdy  <= '0;
            r_mem_rv  <= 1'b0;
            r_mem_wv  <= 1'b0;
            r_mem_ra  <= '0;
            r_mem_wa  <= '0;
            r_mem_wd  <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_g       <= w_g;
            r_ptr     <= w_ptr;
            r_rd_data <= w_rd_data;
            r_rd_rdy  <= w_rd_rdy;
            r_wr_rdy  <= w_wr_rdy;
            r_mem_rv  <= w_mem_rv;
            r_mem_wv  <= w_mem_wv;
            r_mem_ra  <= w_mem_ra;
            r_mem_wa  <= w_mem_wa;
            r_mem_wd  <= w_mem_wd;
            r_busy    <= w_busy;
        end
    end

    assign req_read_ready    = r_rd_rdy;
    assign req_read_data     = r_rd_data;
    assign req_write_ready   = r_wr_rdy;
    assign mem_read_valid    = r_mem_rv;
    assign mem_read_address  = r_mem_ra;
    assign mem_write_valid   = r_mem_wv;
    assign mem_write_address = r_mem_wa;
    assign mem_write_data    = r_mem_wd;
    assign busy              = r_busy;

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Bench for lsu_mem_arbiter: directed scenarios plus random LSU/memory traffic,
// checked every cycle against a phase-level round-robin reference model.
module tb_lsu_mem_arbiter;

    localparam int unsigned T  = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic                   clk;
    logic                   reset;
    logic [T-1:0]           rv, wv, rrdy, wrdy;
    logic [T-1:0][AW-1:0]   raddr, waddr;
    logic [T-1:0][DW-1:0]   wdata, rdata;
    logic                   mrv, mwv, mrr, mwr, busy;
    logic [AW-1:0]          mra, mwa;
    logic [DW-1:0]          mrd, mwd;

    lsu_mem_arbiter #(.THREADS_PER_BLOCK(T), .ADDR_BITS(AW), .DATA_BITS(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_read_valid    (rv),
        .req_read_address  (raddr),
        .req_read_ready    (rrdy),
        .req_read_data     (rdata),
        .req_write_valid   (wv),
        .req_write_address (waddr),
        .req_write_data    (wdata),
        .req_write_ready   (wrdy),
        .mem_read_valid    (mrv),
        .mem_read_address  (mra),
        .mem_read_ready    (mrr),
        .mem_read_data     (mrd),
        .mem_write_valid   (mwv),
        .mem_write_address (mwa),
        .mem_write_data    (mwd),
        .mem_write_ready   (mwr),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = idle, 1 = memory handshake, 2 = relay to LSU.
    int             m_phase, m_g, m_ptr;
    bit             m_rd;
    logic [AW-1:0]  m_addr;
    logic [DW-1:0]  m_wd;
    logic [DW-1:0]  m_rdata [T];

    int  hold [T];
    int  mwait, mem_lat;
    bit  rand_en, prev_mv;
    int  grant_q [$];
    int  mrv_cnt, rd0_cnt;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_g = 0; m_ptr = 0; m_rd = 0;
        for (int i = 0; i < T; i++) m_rdata[i] = '0;
    endtask

    // Apply one clock edge worth of the arbitration rules to the inputs the DUT sampled.
    task automatic model_step();
        case (m_phase)
            0: begin
                for (int k = 0; k < T; k++) begin
                    int idx;
                    idx = (m_ptr + k) % T;
                    if (m_phase == 0 && (rv[idx] || wv[idx])) begin
                        m_g     = idx;
                        m_rd    = rv[idx];
                        m_addr  = rv[idx] ? raddr[idx] : waddr[idx];
                        m_wd    = wdata[idx];
                        m_phase = 1;
                    end
                end
            end
            1: begin
                if (m_rd ? mrr : mwr) begin
                    if (m_rd) m_rdata[m_g] = mrd;
                    m_phase = 2;
                end
            end
            default: begin
                if (!(m_rd ? rv[m_g] : wv[m_g])) begin
                    m_ptr   = (m_g + 1) % T;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    task automatic compare();
        logic [T-1:0] er, ew;
        er = '0; ew = '0;
        if (m_phase == 2 &&  m_rd) er[m_g] = 1'b1;
        if (m_phase == 2 && !m_rd) ew[m_g] = 1'b1;
        chk_eq("busy", 64'(busy), 64'(m_phase != 0));
        chk_eq("mem_read_valid", 64'(mrv), 64'(m_phase == 1 && m_rd));
        chk_eq("mem_write_valid", 64'(mwv), 64'(m_phase == 1 && !m_rd));
        chk_eq("req_read_ready", 64'(rrdy), 64'(er));
        chk_eq("req_write_ready", 64'(wrdy), 64'(ew));
        if (m_phase == 1 && m_rd) chk_eq("mem_read_address", 64'(mra), 64'(m_addr));
        if (m_phase == 1 && !m_rd) begin
            chk_eq("mem_write_address", 64'(mwa), 64'(m_addr));
            chk_eq("mem_write_data", 64'(mwd), 64'(m_wd));
        end
        for (int i = 0; i < T; i++)
            chk_eq($sformatf("req_read_data%0d", i), 64'(rdata[i]), 64'(m_rdata[i]));
    endtask

    // LSUs hold valid until ready (plus optional extra cycles), then release.
    task automatic drive_lsu();
        for (int i = 0; i < T; i++) begin
            if (rrdy[i] && rv[i]) begin
                if (hold[i] > 0) hold[i]--; else rv[i] = 1'b0;
            end
            if (wrdy[i] && wv[i]) begin
                if (hold[i] > 0) hold[i]--; else wv[i] = 1'b0;
            end
            if (rand_en && !rv[i] && !wv[i] && $urandom_range(3) == 0) begin
                int kind;
                kind     = int'($urandom_range(2));
                raddr[i] = AW'($urandom);
                waddr[i] = AW'($urandom);
                wdata[i] = DW'($urandom);
                hold[i]  = int'($urandom_range(2));
                rv[i]    = (kind != 1);
                wv[i]    = (kind != 0);
            end
        end
    endtask

    task automatic set_lat(input int l);
        mem_lat = l;
        mwait   = (l < 0) ? int'($urandom_range(3)) : l;
    endtask

    // Memory answers after mwait cycles; read data is a fixed function of the address.
    task automatic drive_mem();
        if (mrv || mwv) begin
            if (!(mrr || mwr)) begin
                if (mwait <= 0) begin
                    if (mrv) begin
                        mrr = 1'b1;
                        mrd = mra ^ 8'hB5;
                    end else begin
                        mwr = 1'b1;
                    end
                end else begin
                    mwait--;
                end
            end
        end else begin
            mrr = 1'b0;
            mwr = 1'b0;
            mwait = (mem_lat < 0) ? int'($urandom_range(3)) : mem_lat;
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        compare();
        if ((mrv || mwv) && !prev_mv) grant_q.push_back(mrv ? int'(mra) : 256 + int'(mwa));
        prev_mv = mrv || mwv;
        if (mrv) mrv_cnt++;
        if (rrdy[0]) rd0_cnt++;
        drive_lsu();
        drive_mem();
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b0;
        #1;
        chk_eq("reset_ctrl", 64'({mrv, mwv, busy, rrdy, wrdy}), 64'(0));
        chk_eq("reset_addr", 64'({mra, mwa, mwd}), 64'(0));
        chk_eq("reset_rdata", 64'(rdata), 64'(0));
        mrr = 1'b0; mwr = 1'b0; prev_mv = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic int q_at(input int i);
        return (i < grant_q.size()) ? grant_q[i] : -1;
    endfunction

    initial begin
        reset = 1'b1;
        rv = '0; wv = '0; raddr = '0; waddr = '0; wdata = '0;
        mrr = 1'b0; mwr = 1'b0; mrd = '0;
        rand_en = 0; prev_mv = 0; mrv_cnt = 0; rd0_cnt = 0;
        for (int i = 0; i < T; i++) hold[i] = 0;
        set_lat(0);
        model_reset();
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_eq("init_ctrl", 64'({mrv, mwv, busy, rrdy, wrdy}), 64'(0));
        reset = 1'b1;

        // All four threads read together: served 0,1,2,3.
        grant_q.delete();
        for (int i = 0; i < T; i++) raddr[i] = AW'(i);
        rv = '1;
        repeat (20) step();
        chk_eq("rr_count", 64'(grant_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) chk_eq($sformatf("rr_order%0d", i), 64'(q_at(i)), 64'(i));

        // Thread 2 reads 0x10, memory answers 3 cycles after the request.
        set_lat(2); grant_q.delete(); mrv_cnt = 0;
        raddr[2] = 8'h10; rv[2] = 1'b1;
        repeat (12) step();
        chk_eq("single_rd_addr", 64'(q_at(0)), 64'(8'h10));
        chk_eq("single_rd_cycles", 64'(mrv_cnt), 64'(3));
        chk_eq("single_rd_data", 64'(rdata[2]), 64'(8'hA5));
        chk_eq("single_rd_idle", 64'(busy), 64'(0));

        // Thread 3 writes 0x7E to 0x22.
        set_lat(1); grant_q.delete(); mrv_cnt = 0;
        waddr[3] = 8'h22; wdata[3] = 8'h7E; wv[3] = 1'b1;
        repeat (10) step();
        chk_eq("single_wr_grant", 64'(q_at(0)), 64'(256 + 8'h22));
        chk_eq("single_wr_no_read", 64'(mrv_cnt), 64'(0));
        chk_eq("single_wr_done", 64'(wv[3]), 64'(0));

        // Thread 1 read and write together: read first.
        set_lat(0); grant_q.delete();
        raddr[1] = 8'h05; waddr[1] = 8'h06; wdata[1] = 8'h11; rv[1] = 1'b1; wv[1] = 1'b1;
        repeat (12) step();
        chk_eq("prio_first", 64'(q_at(0)), 64'(8'h05));
        chk_eq("prio_second", 64'(q_at(1)), 64'(256 + 8'h06));

        // Pointer now at 2: thread 3 before thread 0.
        grant_q.delete();
        raddr[0] = 8'h30; raddr[3] = 8'h33; rv[0] = 1'b1; rv[3] = 1'b1;
        repeat (12) step();
        chk_eq("wrap_first", 64'(q_at(0)), 64'(8'h33));
        chk_eq("wrap_second", 64'(q_at(1)), 64'(8'h30));

        // Slow LSU: thread 0 holds valid 5 cycles past ready, thread 1 waits.
        rd0_cnt = 0;
        raddr[0] = 8'h40; hold[0] = 5; rv[0] = 1'b1;
        step();
        grant_q.delete();
        raddr[1] = 8'h41; rv[1] = 1'b1;
        repeat (16) step();
        chk_eq("slow_ready_cycles", 64'(rd0_cnt), 64'(6));
        chk_eq("slow_next_grant", 64'(q_at(0)), 64'(8'h41));
        chk_eq("slow_grant_count", 64'(grant_q.size()), 64'(1));

        // Withdrawn read: memory still completes, ready pulses once.
        set_lat(2);
        raddr[2] = 8'h50; rv[2] = 1'b1;
        step();
        rv[2] = 1'b0;
        repeat (8) step();
        chk_eq("withdraw_idle", 64'(busy), 64'(0));

        // Reset during a read wait; the held request is re-issued afterwards.
        set_lat(6);
        raddr[2] = 8'h60; rv[2] = 1'b1;
        repeat (2) step();
        pulse_reset();
        set_lat(0); grant_q.delete();
        repeat (10) step();
        chk_eq("reset_reissue", 64'(q_at(0)), 64'(8'h60));
        chk_eq("reset_reissue_done", 64'(rv[2]), 64'(0));

        // Random traffic with one reset in the middle, then drain.
        set_lat(-1); rand_en = 1;
        repeat (1500) step();
        pulse_reset();
        repeat (1500) step();
        rand_en = 0;
        repeat (300) step();
        chk_eq("drain_all_served", 64'({rv, wv}), 64'(0));
        chk_eq("drain_idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
